// File: rtl/stack_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stack_arbiter_ctrl
// Purpose  : Shares one LIFO store between two requesters (r0 = call/return,
//            r1 = interrupt/exception context). Fixed priority r1 over r0.
//            Occupancy is pre-checked before each 1..4 word burst, and the
//            store strobes are driven one word per cycle. Pop data is
//            returned in LIFO order, and a sticky fault is raised when the
//            store flags disagree with the controller's view.
// Ports    : clock, reset         - clock and synchronous active-high reset
//            rN_req/op/len/wdata  - requester N burst request (N = 0, 1)
//            rN_gnt/word/rvalid/rdata/done/err - requester N burst responses
//            stk_push/pop/din     - store strobes and write data
//            stk_dout/full/empty  - store read data (registered) and flags
//            count, fault         - occupancy and sticky flag-mismatch
// Revision : 1.0 - initial release
// ============================================================================
module stack_arbiter_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             r0_req,
  input  logic             r0_op,
  input  logic [1:0]       r0_len,
  input  logic [WIDTH-1:0] r0_wdata,
  output logic             r0_gnt,
  output logic             r0_word,
  output logic             r0_rvalid,
  output logic [WIDTH-1:0] r0_rdata,
  output logic             r0_done,
  output logic             r0_err,
  input  logic             r1_req,
  input  logic             r1_op,
  input  logic [1:0]       r1_len,
  input  logic [WIDTH-1:0] r1_wdata,
  output logic             r1_gnt,
  output logic             r1_word,
  output logic             r1_rvalid,
  output logic [WIDTH-1:0] r1_rdata,
  output logic             r1_done,
  output logic             r1_err,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  input  logic             stk_full,
  input  logic             stk_empty,
  output logic [CNT_W-1:0] count,
  output logic             fault
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_PUSH = 3'd1;
  localparam logic [2:0] c_POP  = 3'd2;
  localparam logic [2:0] c_LAST = 3'd3;
  localparam logic [2:0] c_DONE = 3'd4;
  localparam logic [2:0] c_ERR  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic             sel_q, sel_d;      // 1: requester 1 owns the burst
  logic [1:0]       beats_q, beats_d;  // words remaining minus one
  logic [CNT_W-1:0] count_q, count_d;
  logic             fault_q, fault_d;
  logic             rvalid_q;          // a pop was issued last cycle

  logic             w_sel;
  logic             w_op;
  logic [1:0]       w_len;
  logic [CNT_W:0]   w_n;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic             w_push;
  logic             w_pop;
  logic             w_done;

  // Winner of arbitration: r1 has priority whenever it is requesting.
  assign w_sel = r1_req;
  assign w_op  = w_sel ? r1_op  : r0_op;
  assign w_len = w_sel ? r1_len : r0_len;
  assign w_n   = {{(CNT_W - 1){1'b0}}, w_len} + (CNT_W + 1)'(1);

  // One extra bit so count + N cannot overflow during the capacity check.
  assign w_push_ok = ({1'b0, count_q} + w_n) <= (CNT_W + 1)'(DEPTH);
  assign w_pop_ok  = {1'b0, count_q} >= w_n;

  assign w_push = (state_q == c_PUSH);
  assign w_pop  = (state_q == c_POP);
  assign w_done = (state_q == c_DONE) || (state_q == c_LAST) || (state_q == c_ERR);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    beats_d = beats_q;
    count_d = count_q;
    case (state_q)
      c_IDLE: begin
        if (r0_req || r1_req) begin
          sel_d   = w_sel;
          beats_d = w_len;
          if (w_op) state_d = w_pop_ok  ? c_POP  : c_ERR;
          else      state_d = w_push_ok ? c_PUSH : c_ERR;
        end
      end
      c_PUSH: begin
        count_d = count_q + 1'b1;
        if (beats_q == 2'd0) state_d = c_DONE;
        else                 beats_d = beats_q - 1'b1;
      end
      c_POP: begin
        count_d = count_q - 1'b1;
        if (beats_q == 2'd0) state_d = c_LAST;
        else                 beats_d = beats_q - 1'b1;
      end
      default: state_d = c_IDLE;  // LAST, DONE, ERR and any illegal code
    endcase
  end

  // Sticky: store disagrees with an issued strobe, or claims room while the
  // controller believes it is full.
  assign fault_d = fault_q
                 | (w_push & stk_full)
                 | (w_pop  & stk_empty)
                 | ((state_q == c_IDLE) && (count_q == CNT_W'(DEPTH)) && !stk_full);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= c_IDLE;
      sel_q    <= 1'b0;
      beats_q  <= 2'd0;
      count_q  <= '0;
      fault_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      beats_q  <= beats_d;
      count_q  <= count_d;
      fault_q  <= fault_d;
      rvalid_q <= w_pop;
    end
  end

  // Store read data is registered, so rvalid trails each pop strobe by one.
  assign stk_push  = w_push;
  assign stk_pop   = w_pop;
  assign stk_din   = w_push ? (sel_q ? r1_wdata : r0_wdata) : '0;

  assign r0_gnt    = (w_push | w_pop) & ~sel_q;
  assign r1_gnt    = (w_push | w_pop) &  sel_q;
  assign r0_word   = w_push & ~sel_q;
  assign r1_word   = w_push &  sel_q;
  assign r0_rvalid = rvalid_q & ~sel_q;
  assign r1_rvalid = rvalid_q &  sel_q;
  assign r0_rdata  = r0_rvalid ? stk_dout : '0;
  assign r1_rdata  = r1_rvalid ? stk_dout : '0;
  assign r0_done   = w_done & ~sel_q;
  assign r1_done   = w_done &  sel_q;
  assign r0_err    = (state_q == c_ERR) & ~sel_q;
  assign r1_err    = (state_q == c_ERR) &  sel_q;

  assign count     = count_q;
  assign fault     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_arbiter_ctrl
// Purpose  : Self-checking bench for stack_arbiter_ctrl. Contains a simple
//            32-word LIFO store and a queue-based reference of the stack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack_arbiter_ctrl;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int CNT_W = 6;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             r0_req = 0, r0_op = 0, r1_req = 0, r1_op = 0;
  logic [1:0]       r0_len = 0, r1_len = 0;
  logic [WIDTH-1:0] r0_wdata = 0, r1_wdata = 0;
  logic             r0_gnt, r0_word, r0_rvalid, r0_done, r0_err;
  logic             r1_gnt, r1_word, r1_rvalid, r1_done, r1_err;
  logic [WIDTH-1:0] r0_rdata, r1_rdata, stk_din;
  logic [WIDTH-1:0] stk_dout;
  logic             stk_push, stk_pop, stk_full, stk_empty, fault;
  logic [CNT_W-1:0] count;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 0;

  logic [WIDTH-1:0] model_q[$];   // reference stack contents, top at end
  logic [WIDTH-1:0] wd[4];        // words of the burst being issued

  always #5 clock = ~clock;

  stack_arbiter_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .r0_req(r0_req), .r0_op(r0_op), .r0_len(r0_len), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_word(r0_word), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r0_done(r0_done), .r0_err(r0_err),
    .r1_req(r1_req), .r1_op(r1_op), .r1_len(r1_len), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_word(r1_word), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .r1_done(r1_done), .r1_err(r1_err),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din), .stk_dout(stk_dout),
    .stk_full(stk_full), .stk_empty(stk_empty), .count(count), .fault(fault)
  );

  // Store: synchronous LIFO with registered read data, reset with the DUT.
  logic [WIDTH-1:0] mem [DEPTH];
  int               sp;
  assign stk_full  = (sp == DEPTH);
  assign stk_empty = (sp == 0);
  always @(posedge clock) begin
    if (reset) begin
      sp       <= 0;
      stk_dout <= '0;
    end else if (stk_push && sp < DEPTH) begin
      mem[sp] <= stk_din;
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_dout <= mem[sp-1];
      sp       <= sp - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Invariants sampled every cycle once running.
  always @(negedge clock) begin
    if (mon_en) begin
      check("gnt_excl", {31'd0, r0_gnt & r1_gnt}, 32'd0);
      check("strobe_excl", {31'd0, stk_push & stk_pop}, 32'd0);
      check("fault_clear", {31'd0, fault}, 32'd0);
    end
  end

  function automatic logic gnt_of(input bit rq);   return rq ? r1_gnt    : r0_gnt;    endfunction
  function automatic logic done_of(input bit rq);  return rq ? r1_done   : r0_done;   endfunction
  function automatic logic err_of(input bit rq);   return rq ? r1_err    : r0_err;    endfunction
  function automatic logic rv_of(input bit rq);    return rq ? r1_rvalid : r0_rvalid; endfunction
  function automatic logic word_of(input bit rq);  return rq ? r1_word   : r0_word;   endfunction
  function automatic logic [31:0] rd_of(input bit rq); return rq ? r1_rdata : r0_rdata; endfunction

  task automatic drive(input bit rq, input bit req, input bit op, input logic [1:0] len,
                       input logic [31:0] wdata);
    if (rq) begin r1_req = req; r1_op = op; r1_len = len; r1_wdata = wdata; end
    else    begin r0_req = req; r0_op = op; r0_len = len; r0_wdata = wdata; end
  endtask

  task automatic reset_dut();
    @(negedge clock); reset = 1'b1;
    r0_req = 0; r1_req = 0;
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    model_q.delete();
  endtask

  // Issues one burst from requester rq and checks it cycle by cycle against
  // the capacity rule and the reference stack.
  task automatic do_burst(input bit rq, input bit op, input int len);
    int  n;
    int  sz;
    bit  ok;
    bit  act;
    n  = len + 1;
    sz = model_q.size();
    ok = op ? (sz >= n) : (sz + n <= DEPTH);
    @(negedge clock);
    drive(rq, 1'b1, op, 2'(len), wd[0]);
    @(posedge clock);
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clock);
      if (!ok) begin
        check("ref_done", {31'd0, done_of(rq)}, 32'd1);
        check("ref_err",  {31'd0, err_of(rq)},  32'd1);
        check("ref_nostrobe", {31'd0, stk_push | stk_pop}, 32'd0);
        check("ref_count", {26'd0, count}, sz);
        drive(rq, 1'b0, op, 2'(len), wd[0]);
        break;
      end
      act = (c <= n);
      check("gnt",   {31'd0, gnt_of(rq)},  {31'd0, act});
      check("ogn",   {31'd0, gnt_of(!rq)}, 32'd0);
      check("push",  {31'd0, stk_push}, {31'd0, act & !op});
      check("pop",   {31'd0, stk_pop},  {31'd0, act & op});
      if (!op && act) begin
        check("word", {31'd0, word_of(rq)}, 32'd1);
        check("din",  stk_din, wd[c-1]);
      end
      if (op) begin
        check("rvalid", {31'd0, rv_of(rq)}, {31'd0, c >= 2});
        if (c >= 2) check("rdata", rd_of(rq), model_q.pop_back());
      end
      check("done", {31'd0, done_of(rq)}, {31'd0, c == n + 1});
      if (c == n + 1) begin
        check("err", {31'd0, err_of(rq)}, 32'd0);
        check("count", {26'd0, count}, op ? model_q.size() : sz + n);
        drive(rq, 1'b0, op, 2'(len), wd[0]);
      end
      if (!op && act) begin
        @(posedge clock); #1;
        if (c < n) begin
          if (rq) r1_wdata = wd[c]; else r0_wdata = wd[c];
        end
      end
    end
    if (ok && !op)
      for (int i = 0; i < n; i++) model_q.push_back(wd[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_dut();
    // Reset state
    @(negedge clock);
    check("rst_count", {26'd0, count}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_gnt", {30'd0, r1_gnt, r0_gnt}, 32'd0);
    check("rst_done", {30'd0, r1_done, r0_done}, 32'd0);
    check("rst_rdata", r0_rdata | r1_rdata, 32'd0);
    check("rst_din", stk_din, 32'd0);
    mon_en = 1;

    // Single-word push
    wd[0] = 32'hDEADBEEF;
    do_burst(0, 0, 0);
    // Pop of 2 with only 1 stored is refused
    do_burst(0, 1, 1);
    // LIFO ordering round trip on requester 1
    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC;
    do_burst(1, 0, 2);
    do_burst(1, 1, 2);

    // Simultaneous requests: r1 wins, r0 follows after done + one IDLE cycle
    @(negedge clock);
    drive(1, 1, 0, 2'd1, 32'h11);
    drive(0, 1, 0, 2'd0, 32'h99);
    @(posedge clock);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      check("arb_g1", {31'd0, r1_gnt}, {31'd0, c <= 2});
      check("arb_g0", {31'd0, r0_gnt}, {31'd0, c == 5});
      check("arb_d1", {31'd0, r1_done}, {31'd0, c == 3});
      check("arb_d0", {31'd0, r0_done}, {31'd0, c == 6});
      if (c == 3) r1_req = 0;
      if (c == 6) r0_req = 0;
      if (c == 1) begin @(posedge clock); #1 r1_wdata = 32'h22; end
    end
    model_q.push_back(32'h11); model_q.push_back(32'h22); model_q.push_back(32'h99);
    check("arb_count", {26'd0, count}, model_q.size());

    // Drain, then fill to capacity with eight 4-word bursts
    do_burst(0, 1, 3);
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 4; i++) wd[i] = $urandom;
      do_burst(1, 0, 3);
    end
    @(negedge clock);
    check("full_count", {26'd0, count}, 32'd32);
    check("full_flag", {31'd0, stk_full}, 32'd1);
    check("full_fault", {31'd0, fault}, 32'd0);
    wd[0] = 32'h5;
    do_burst(0, 0, 0);  // refused, count stays 32

    // Reset in the middle of a 4-word push
    reset_dut();
    wd[0] = 1; wd[1] = 2; wd[2] = 3; wd[3] = 4;
    @(negedge clock);
    drive(0, 1, 0, 2'd3, wd[0]);
    @(posedge clock);
    @(negedge clock);
    check("mid_push1", {31'd0, stk_push}, 32'd1);
    @(posedge clock); #1 r0_wdata = wd[1];
    @(negedge clock);
    check("mid_push2", {31'd0, stk_push}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("mid_gnt", {31'd0, r0_gnt}, 32'd0);
    check("mid_push", {31'd0, stk_push}, 32'd0);
    check("mid_count", {26'd0, count}, 32'd0);
    reset = 1'b0; r0_req = 0;
    model_q.delete();
    wd[0] = 32'hCAFE0001; wd[1] = 32'hCAFE0002;
    do_burst(0, 0, 1);

    // Randomized traffic against the reference stack
    for (int t = 0; t < 80; t++) begin
      bit rq;
      bit op;
      rq = 1'($urandom);
      op = ($urandom_range(0, 99) < 45);
      for (int i = 0; i < 4; i++) wd[i] = $urandom;
      do_burst(rq, op, int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(posedge clock);
    end
    @(negedge clock);
    check("final_count", {26'd0, count}, model_q.size());
    check("final_fault", {31'd0, fault}, 32'd0);
    mon_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stack_arbiter_ctrl.md
Name: stack_arbiter_ctrl

Overview:
Controller that shares one 32x32 LIFO store between two requesters and sequences multi-word bursts on it.
- Requester 0 is the call/return unit.
- Requester 1 is the interrupt/exception context unit.
- The block arbitrates, checks capacity before any stack operation, and drives the store's push/pop strobes one word per cycle.
- It tracks occupancy, returns pop data in LIFO order, and flags refused bursts and store-flag mismatches.

Parameters:
WIDTH, 32, data word width
DEPTH, 32, store capacity in words
CNT_W, 6, occupancy counter width (holds 0..DEPTH)

Ports:
clock  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high; clears all state
r0_req  in  1  requester 0 request, held high until r0_done
r0_op  in  1  0 = push, 1 = pop
r0_len  in  2  burst length minus one (1..4 words)
r0_wdata  in  WIDTH  push word; requester advances it after each r0_word pulse
r0_gnt  out  1  high for the whole granted burst
r0_word  out  1  pulse: r0_wdata consumed this cycle
r0_rvalid  out  1  pulse: r0_rdata valid
r0_rdata  out  WIDTH  popped word
r0_done  out  1  one-cycle burst completion pulse
r0_err  out  1  with r0_done: burst refused, no stack op issued
r1_req, r1_op, r1_len, r1_wdata, r1_gnt, r1_word, r1_rvalid, r1_rdata, r1_done, r1_err: same as requester 0, for requester 1
stk_push  out  1  store push strobe
stk_pop  out  1  store pop strobe
stk_din  out  WIDTH  store write data
stk_dout  in  WIDTH  store read data, registered, valid the cycle after stk_pop
stk_full  in  1  store full flag
stk_empty  in  1  store empty flag
count  out  CNT_W  controller occupancy
fault  out  1  sticky: store flag disagrees with an issued op

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE, count = 0, fault = 0.
  - All gnt/word/rvalid/done/err/stk_push/stk_pop = 0; rdata and stk_din = 0.
  - Reset mid-burst aborts the burst; outputs are zero from the next cycle.
  - The store must be reset by the same signal (integration rule).
- States: IDLE, PUSH, POP, LAST, DONE, ERR.
- IDLE arbitration:
  - Samples requests at each edge; fixed priority, r1 over r0.
  - Let N = len + 1 for the winner.
  - Push refused if count + N > DEPTH; pop refused if count < N.
  - Accepted push goes to PUSH, accepted pop goes to POP, refused goes to ERR.
  - Winner's gnt rises the next cycle.
- PUSH (N cycles): each cycle stk_push = 1, stk_din = winner wdata, word pulse, count + 1. After the Nth cycle, go to DONE.
- DONE: one cycle, done = 1, gnt = 0, then IDLE.
- POP (N cycles): each cycle stk_pop = 1, count - 1.
  - rvalid/rdata (from stk_dout) is asserted the cycle after each stk_pop.
  - After the Nth cycle, go to LAST.
- LAST: final rvalid plus done in the same cycle, then IDLE.
- ERR: one cycle, done = 1 and err = 1; no stk_push/stk_pop; count unchanged; then IDLE.
- Timing (request sampled at edge k):
  - Push: stk_push in cycles k+1..k+N; done at k+N+1.
  - Pop: stk_pop in cycles k+1..k+N; rvalid in k+2..k+N+1; done at k+N+1.
  - Refused: done/err at k+1.
- At most one gnt is high at any time; stk_push and stk_pop are never both high.
- IDLE always lasts at least one cycle between bursts. A requester holding req after done is re-arbitrated against the other.
- req dropped mid-burst is ignored; the burst completes. op/len are latched at grant.
- Fault:
  - Set if stk_full = 1 in a cycle with stk_push, or stk_empty = 1 in a cycle with stk_pop.
  - Set if count == DEPTH and stk_full = 0 while IDLE.
  - Cleared only by reset; operations continue.
- count never wraps: saturation is impossible by the pre-check.

Test Plan:
1. Reset, then r0 push len=0 wdata=0xDEADBEEF → stk_push one cycle with stk_din=0xDEADBEEF, r0_done next cycle, count=1, r0_err=0.
2. r1 push len=2 (0xA, 0xB, 0xC), then r1 pop len=2 → r1_rdata sequence 0xC, 0xB, 0xA on consecutive rvalid; done with last rvalid; count 3→0.
3. r0 and r1 both raise req at the same edge → r1_gnt first, r0_gnt only after r1_done plus one IDLE cycle; gnts never overlap.
4. count=1, r0 pop len=1 → r0_done=r0_err=1 at k+1; no stk_pop; count stays 1.
5. Eight r1 pushes of len=3 → count=32, stk_full=1, fault=0. Then r0 push len=0 → err, count=32.
6. reset asserted after 2 of 4 words of a push burst → the next cycle has gnt=0, stk_push=0, count=0, state IDLE. A new r0 push is then accepted normally.
